// File: rtl/jimmy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jimmy_pkg
// Description : Shared definitions for the Jimmy CPU: opcode encodings,
//               register codes, fetch FSM states and the instruction
//               length decode used by the fetch unit, decoder and assembler.
// Revision    : 1.0 - initial release
// ============================================================================
package jimmy_pkg;

    // Base opcodes; register fields occupy the low bits where applicable.
    localparam logic [7:0] c_OP_ADD     = 8'h00;
    localparam logic [7:0] c_OP_MUL     = 8'h20;
    localparam logic [7:0] c_OP_MOV     = 8'h40;
    localparam logic [7:0] c_OP_NOP     = 8'h70;
    localparam logic [7:0] c_OP_MOV_IMM = 8'h80;
    localparam logic [7:0] c_OP_CMP_IMM = 8'h8C;
    localparam logic [7:0] c_OP_DEC     = 8'h90;
    localparam logic [7:0] c_OP_INPUT   = 8'h98;
    localparam logic [7:0] c_OP_OUTPUT  = 8'h9C;
    localparam logic [7:0] c_OP_BEQ     = 8'hA0;
    localparam logic [7:0] c_OP_BHI     = 8'hA4;
    localparam logic [7:0] c_OP_BRA     = 8'hA8;

    // Register codes.
    localparam logic [1:0] c_R0 = 2'd0;
    localparam logic [1:0] c_R1 = 2'd1;
    localparam logic [1:0] c_R2 = 2'd2;
    localparam logic [1:0] c_R3 = 2'd3;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        F_OP  = 2'd0,
        F_IMM = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Branches, MOV immediate and CMP immediate carry a second byte.
    function automatic logic is_two_byte(input logic [7:0] opcode);
        return (opcode[7:5] == 3'b101)    ||
               (opcode[7:2] == 6'b100000) ||
               (opcode[7:2] == 6'b100011);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Program-memory sequencer for the Jimmy CPU. Owns the PC,
//               assembles 1/2-byte instructions from combinational ROM data,
//               presents them over valid/ready and applies branch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import jimmy_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        instr_opcode,
    output logic [7:0]        instr_imm,
    output logic              instr_len,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target
);

    localparam logic [ADDR_W-1:0] c_PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state_q,  state_d;
    logic [ADDR_W-1:0] pc_q,     pc_d;
    logic              valid_q,  valid_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        imm_q,    imm_d;
    logic              len_q,    len_d;
    logic [ADDR_W-1:0] ipc_q,    ipc_d;

    // State and instruction registers; reset drops any partial fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= F_OP;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            opcode_q <= 8'h00;
            imm_q    <= 8'h00;
            len_q    <= 1'b0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            imm_q    <= imm_d;
            len_q    <= len_d;
            ipc_q    <= ipc_d;
        end
    end

    // Next-state logic; a branch overrides the sequencer in every state,
    // and a handshake in the same cycle is simply absorbed by dropping valid.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        imm_d    = imm_q;
        len_d    = len_q;
        ipc_d    = ipc_q;

        if (branch_taken) begin
            pc_d    = branch_target;
            state_d = F_OP;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                F_OP: begin
                    opcode_d = mem_data;
                    ipc_d    = pc_q;
                    pc_d     = pc_q + c_PC_ONE;
                    if (is_two_byte(mem_data)) begin
                        state_d = F_IMM;
                    end else begin
                        imm_d   = 8'h00;
                        len_d   = 1'b0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                F_IMM: begin
                    imm_d   = mem_data;
                    len_d   = 1'b1;
                    pc_d    = pc_q + c_PC_ONE;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    if (valid_q && instr_ready) begin
                        valid_d = 1'b0;
                        state_d = F_OP;
                    end
                end
                default: begin
                    state_d = F_OP;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign mem_addr     = pc_q;
    assign instr_valid  = valid_q;
    assign instr_opcode = opcode_q;
    assign instr_imm    = imm_q;
    assign instr_len    = len_q;
    assign instr_pc     = ipc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. A second
//               instance with RESET_PC = 8'hFF exercises PC wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_ready;
    logic       branch_taken;
    logic [7:0] branch_target;

    logic [7:0] rom_a [256];
    logic [7:0] rom_b [256];

    logic [7:0] a_addr, a_data, a_opcode, a_imm, a_pc;
    logic       a_valid, a_len;
    logic [7:0] b_addr, b_data, b_opcode, b_imm, b_pc;
    logic       b_valid, b_len;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign a_data = rom_a[a_addr];
    assign b_data = rom_b[b_addr];

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (a_addr),
        .mem_data      (a_data),
        .instr_valid   (a_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (a_opcode),
        .instr_imm     (a_imm),
        .instr_len     (a_len),
        .instr_pc      (a_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'hFF)) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .mem_addr      (b_addr),
        .mem_data      (b_data),
        .instr_valid   (b_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (b_opcode),
        .instr_imm     (b_imm),
        .instr_len     (b_len),
        .instr_pc      (b_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_a[i] = 8'h70;
            rom_b[i] = 8'h70;
        end
        rom_a[0]  = 8'h82; rom_a[1]  = 8'h00; rom_a[2] = 8'h98;
        rom_a[4]  = 8'h9C; rom_a[5]  = 8'h80; rom_a[6] = 8'h33;
        rom_a[10] = 8'hA8; rom_a[11] = 8'h04; rom_a[12] = 8'h70;
        rom_b[255] = 8'h8C; rom_b[0] = 8'h00;

        reset = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
        tick(); tick();
        chk("rst_valid",  a_valid,  0);
        chk("rst_opcode", a_opcode, 0);
        chk("rst_imm",    a_imm,    0);
        chk("rst_len",    a_len,    0);
        chk("rst_pc",     a_pc,     0);
        chk("rst_addr",   a_addr,   8'h00);
        chk("rst_addr_b", b_addr,   8'hFF);

        // 1: two-byte MOV imm at 0
        reset = 1'b0; instr_ready = 1'b1;
        tick();
        chk("t1_fimm_valid", a_valid, 0);
        chk("t1_fimm_addr",  a_addr,  8'h01);
        tick();
        chk("t1_valid",  a_valid,  1);
        chk("t1_opcode", a_opcode, 8'h82);
        chk("t1_imm",    a_imm,    8'h00);
        chk("t1_len",    a_len,    1);
        chk("t1_pc",     a_pc,     8'h00);
        tick();
        chk("t1_consumed", a_valid, 0);
        chk("t1_next_addr", a_addr, 8'h02);

        // 2: INPUT R0 held under back-pressure
        instr_ready = 1'b0;
        tick();
        chk("t2_valid", a_valid, 1);
        chk("t2_len",   a_len,   0);
        chk("t2_imm",   a_imm,   0);
        chk("t2_pc",    a_pc,    8'h02);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid",  a_valid,  1);
            chk("t2_hold_opcode", a_opcode, 8'h98);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        chk("t2_consumed", a_valid, 0);
        chk("t2_addr",     a_addr,  8'h03);

        // 3: redirect to 10, then BRA 4 taken in its handshake cycle
        instr_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h0A;
        tick();
        branch_taken = 1'b0;
        chk("t3_jump_addr", a_addr, 8'h0A);
        tick(); tick();
        chk("t3_valid",  a_valid,  1);
        chk("t3_opcode", a_opcode, 8'hA8);
        chk("t3_imm",    a_imm,    8'h04);
        chk("t3_pc",     a_pc,     8'h0A);
        instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h04;
        tick();
        branch_taken = 1'b0; instr_ready = 1'b0;
        chk("t3_br_valid", a_valid, 0);
        chk("t3_br_addr",  a_addr,  8'h04);
        tick();
        chk("t3_next_valid",  a_valid,  1);
        chk("t3_next_pc",     a_pc,     8'h04);
        chk("t3_next_opcode", a_opcode, 8'h9C);

        // 4: branch during F_IMM of MOV imm at 5
        instr_ready = 1'b1;
        tick();
        chk("t4_consumed", a_addr, 8'h05);
        tick();
        chk("t4_fimm_addr",  a_addr,  8'h06);
        chk("t4_fimm_valid", a_valid, 0);
        branch_taken = 1'b1; branch_target = 8'h0C;
        tick();
        branch_taken = 1'b0;
        chk("t4_no_pulse", a_valid, 0);
        chk("t4_br_addr",  a_addr,  8'h0C);
        tick();
        chk("t4_valid",  a_valid,  1);
        chk("t4_pc",     a_pc,     8'h0C);
        chk("t4_opcode", a_opcode, 8'h70);

        // 6: reset while holding a valid instruction
        instr_ready = 1'b0; reset = 1'b1;
        tick();
        chk("t6_valid",  a_valid,  0);
        chk("t6_opcode", a_opcode, 0);
        chk("t6_imm",    a_imm,    0);
        chk("t6_len",    a_len,    0);
        chk("t6_pc",     a_pc,     0);
        chk("t6_addr",   a_addr,   8'h00);

        // 5: CMP imm at 8'hFF with immediate from address 0 (second instance)
        reset = 1'b0;
        tick();
        chk("t5_fimm_addr", b_addr, 8'h00);
        tick();
        chk("t5_valid",  b_valid,  1);
        chk("t5_opcode", b_opcode, 8'h8C);
        chk("t5_imm",    b_imm,    8'h00);
        chk("t5_len",    b_len,    1);
        chk("t5_pc",     b_pc,     8'hFF);
        chk("t5_addr",   b_addr,   8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Sequences the 8-bit program memory for the Jimmy CPU. Holds the program counter and drives the ROM address bus. Assembles 1- or 2-byte instructions from the combinational ROM read data and hands them to the execute stage over a valid/ready handshake. Applies branch redirects from the execute stage.

Parameters:
ADDR_W, 8, program address width; the PC wraps modulo 2**ADDR_W.
RESET_PC, 8'd0, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
mem_addr  output  ADDR_W  ROM address. Driven directly from the internal fetch pointer.
mem_data  input  8  ROM read data. Combinational, valid in the same cycle as mem_addr.
instr_valid  output  1  the instruction outputs hold a complete instruction.
instr_ready  input  1  the execute stage accepts the instruction this cycle.
instr_opcode  output  8  first instruction byte.
instr_imm  output  8  second byte (immediate or branch target); 0 for 1-byte instructions.
instr_len  output  1  0 = 1-byte instruction, 1 = 2-byte instruction.
instr_pc  output  ADDR_W  address of the opcode byte.
branch_taken  input  1  redirect request, sampled every cycle.
branch_target  input  ADDR_W  new PC when branch_taken = 1.

Behaviour:
- Reset (synchronous, highest priority):
  - pc = RESET_PC, state = F_OP.
  - instr_valid = 0; instr_opcode, instr_imm, instr_len, instr_pc = 0.
  - Reset asserted mid-instruction discards any partial fetch.
- mem_addr always equals pc.
- Length decode:
  - 2-byte when opcode[7:5] = 3'b101 (branches), or opcode[7:2] = 6'b100000 (MOV imm), or opcode[7:2] = 6'b100011 (CMP imm).
  - All other opcodes are 1-byte, including NOP 8'h70, ADD, MUL, MOV, DEC, INPUT and OUTPUT.
- FSM states: F_OP, F_IMM, HOLD.
  - F_OP: latch opcode = mem_data, instr_pc = pc, pc = pc+1.
    - 1-byte opcode: instr_imm = 0, instr_len = 0, go to HOLD with instr_valid = 1.
    - 2-byte opcode: go to F_IMM.
  - F_IMM: latch instr_imm = mem_data, instr_len = 1, pc = pc+1, go to HOLD with instr_valid = 1.
  - HOLD: outputs stay stable while instr_ready = 0. On instr_valid & instr_ready:
    - instr_valid drops next cycle and state goes to F_OP (no prefetch).
- Latency from entering F_OP: 1-byte instruction valid after 1 cycle; 2-byte valid after 2 cycles.
- Minimum throughput: one instruction per 2 cycles (1-byte) or 3 cycles (2-byte).
- Branch (priority below reset, above everything else):
  - branch_taken = 1 in any state sets pc = branch_target, state = F_OP and instr_valid = 0 on the next edge.
  - Any partial fetch is discarded.
  - Branch together with a valid & ready handshake in the same cycle: the handshake completes (instruction consumed) and the redirect still applies.
- PC arithmetic is modulo 2**ADDR_W: 8'hFF + 1 = 8'h00. A 2-byte instruction at 8'hFF takes its immediate from 8'h00.
- instr_ready is ignored while instr_valid = 0.
- instr_opcode, instr_imm, instr_len and instr_pc never change while instr_valid = 1 and no branch or reset occurs.

Decomposition:
- Package jimmy_pkg holds:
  - opcode constants (ADD, MUL, MOV, MOV_IMM, CMP_IMM, DEC, INPUT, OUTPUT, BRA, BHI, BEQ, NOP);
  - register codes R0–R3;
  - the fetch_state_t enum {F_OP, F_IMM, HOLD};
  - function is_two_byte(opcode), shared with the decoder and the assembler tooling.
- No sub-module; the length decode is the package function.

Test Plan:
1. ROM[0..1] = 8'h82, 8'h00; instr_ready = 1 after reset release → instr_valid = 1 two cycles after F_OP entry with opcode 8'h82, imm 8'h00, len 1, instr_pc 0; next fetch reads address 2.
2. ROM[2] = 8'h98 (INPUT R0); instr_ready held 0 for 5 cycles → valid stays 1 and opcode stays 8'h98 for all 5 cycles; on the ready cycle it is consumed, valid = 0 next cycle, mem_addr = 3.
3. ROM[10..11] = 8'hA8, 8'h04 (BRA 4); execute asserts branch_taken with target 8'h04 in the handshake cycle → next cycle mem_addr = 4, valid = 0; next instruction has instr_pc = 4.
4. branch_taken to 8'h0C asserted while in F_IMM of a 2-byte instruction → partial fetch dropped, no valid pulse; next valid instruction has instr_pc = 8'h0C.
5. RESET_PC = 8'hFF, ROM[FF] = 8'h8C (CMP imm), ROM[00] = 8'h00 → opcode 8'h8C, imm 8'h00, instr_pc 8'hFF; next fetch at address 1.
6. reset asserted for one cycle while in HOLD with valid = 1 → next cycle valid = 0, all outputs 0, mem_addr = RESET_PC.
